cp_symbol_scheduler: RTL and testbench

Sequences the cyclic-prefix removal stage on a per-OFDM-symbol basis. Counts incoming time-domain samples against the slot symbol pattern, issues one trigger pulse per symbol with the correct long/short CP flag, and tracks symbol and slot numbers. Sits between the slot-timing/framer logic and the CP removal block, driving its trigger, long-CP and sync inputs.

---
 rtl/cp_symbol_scheduler_pkg.sv | 25 ++
 rtl/cp_symbol_scheduler_counter.sv | 46 ++++
 rtl/cp_symbol_scheduler.sv | 158 +++++++++++++++
 tb/tb_cp_symbol_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_symbol_scheduler_pkg.sv
// Shared types and constants for the cyclic-prefix symbol scheduler.
// Symbol lengths here match the default numerology; the top recomputes them from its parameters.
package cp_symbol_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int FFT_SIZE_DEF         = 4096;
    localparam int CP_LEN1_DEF          = 352;
    localparam int CP_LEN2_DEF          = 288;
    localparam int SYMBOLS_PER_SLOT_DEF = 14;
    localparam int LONG_CP_PERIOD_DEF   = 7;

    localparam int SYM_LEN_LONG  = FFT_SIZE_DEF + CP_LEN1_DEF;
    localparam int SYM_LEN_SHORT = FFT_SIZE_DEF + CP_LEN2_DEF;

    // Symbol i carries the long CP when i is a multiple of the period.
    function automatic logic is_long_cp(input logic [3:0] sym, input int period);
        return (int'(sym) % period) == 0;
    endfunction

endpackage

// File: rtl/cp_symbol_scheduler_counter.sv
// Valid-sample counter for one OFDM symbol; flags the last sample of the symbol.
module cp_sample_counter #(
    parameter int CNT_WIDTH     = 13,
    parameter int SYM_LEN_LONG  = 4448,
    parameter int SYM_LEN_SHORT = 4384
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 count_en,
    input  logic                 restart,
    input  logic                 sample_valid,
    input  logic                 long_flag,
    output logic [CNT_WIDTH-1:0] sample_cnt,
    output logic                 symbol_done
);

    localparam logic [CNT_WIDTH-1:0] LAST_LONG  = CNT_WIDTH'(SYM_LEN_LONG - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_SHORT = CNT_WIDTH'(SYM_LEN_SHORT - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] last_idx;

    always_comb begin
        last_idx    = long_flag ? LAST_LONG : LAST_SHORT;
        symbol_done = count_en && sample_valid && (cnt_q == last_idx);
        cnt_d       = cnt_q;
        // A restart outranks a coincident symbol completion.
        if (restart) begin
            cnt_d = '0;
        end else if (count_en && sample_valid) begin
            cnt_d = symbol_done ? '0 : cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample_cnt = cnt_q;

endmodule

// File: rtl/cp_symbol_scheduler.sv
// Per-symbol trigger generator for CP removal: tracks symbol/slot position against
// the long/short CP pattern and resynchronises on misaligned slot_sync pulses.
module cp_symbol_scheduler
    import cp_symbol_scheduler_pkg::*;
#(
    parameter int FFT_SIZE         = FFT_SIZE_DEF,
    parameter int CP_LEN1          = CP_LEN1_DEF,
    parameter int CP_LEN2          = CP_LEN2_DEF,
    parameter int SYMBOLS_PER_SLOT = SYMBOLS_PER_SLOT_DEF,
    parameter int LONG_CP_PERIOD   = LONG_CP_PERIOD_DEF,
    parameter int CNT_WIDTH        = 13,
    parameter int SLOT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  slot_sync,
    input  logic                  sample_valid,
    input  logic                  sync_mode,
    output logic                  dout_trigger,
    output logic                  long_cp,
    output logic                  dout_sync,
    output logic [3:0]            symbol_num,
    output logic [SLOT_WIDTH-1:0] slot_cnt,
    output logic [CNT_WIDTH-1:0]  sample_cnt,
    output logic                  busy,
    output logic                  sync_err,
    output logic [7:0]            sync_err_cnt
);

    localparam int              LEN_LONG  = FFT_SIZE + CP_LEN1;
    localparam int              LEN_SHORT = FFT_SIZE + CP_LEN2;
    localparam logic [3:0]      LAST_SYM  = 4'(SYMBOLS_PER_SLOT - 1);

    generate
        if (LEN_LONG - 1 >= (1 << CNT_WIDTH)) begin : g_cnt_width_check
            $error("CNT_WIDTH too small for FFT_SIZE+CP_LEN1-1");
        end
    endgenerate

    state_t                state_q, state_d;
    logic                  trigger_q, trigger_d;
    logic                  long_cp_q, long_cp_d;
    logic [3:0]            symbol_num_q, symbol_num_d;
    logic [SLOT_WIDTH-1:0] slot_cnt_q, slot_cnt_d;
    logic                  sync_err_q, sync_err_d;
    logic [7:0]            sync_err_cnt_q, sync_err_cnt_d;

    logic count_en;
    logic symbol_done;
    logic aligned_sync;
    logic misaligned_sync;
    logic restart;

    // Control strobes are built outside the FSM process so the counter's
    // done strobe never feeds back into its own enable.
    assign count_en        = (state_q == RUN) && enable;
    assign aligned_sync    = symbol_done && (symbol_num_q == LAST_SYM);
    assign misaligned_sync = count_en && slot_sync && !aligned_sync;
    assign restart         = misaligned_sync ||
                             ((state_q == WAIT_SYNC) && enable && slot_sync);

    cp_sample_counter #(
        .CNT_WIDTH     (CNT_WIDTH),
        .SYM_LEN_LONG  (LEN_LONG),
        .SYM_LEN_SHORT (LEN_SHORT)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .count_en     (count_en),
        .restart      (restart),
        .sample_valid (sample_valid),
        .long_flag    (long_cp_q),
        .sample_cnt   (sample_cnt),
        .symbol_done  (symbol_done)
    );

    always_comb begin
        state_d        = state_q;
        trigger_d      = 1'b0;
        long_cp_d      = long_cp_q;
        symbol_num_d   = symbol_num_q;
        slot_cnt_d     = slot_cnt_q;
        sync_err_d     = 1'b0;
        sync_err_cnt_d = sync_err_cnt_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (slot_sync) begin
                    state_d      = RUN;
                    trigger_d    = 1'b1;
                    symbol_num_d = '0;
                    long_cp_d    = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (misaligned_sync) begin
                    trigger_d    = 1'b1;
                    symbol_num_d = '0;
                    long_cp_d    = 1'b1;
                    sync_err_d   = 1'b1;
                    if (sync_err_cnt_q != 8'hFF) begin
                        sync_err_cnt_d = sync_err_cnt_q + 8'd1;
                    end
                end else if (symbol_done) begin
                    trigger_d = 1'b1;
                    if (symbol_num_q == LAST_SYM) begin
                        symbol_num_d = '0;
                        slot_cnt_d   = slot_cnt_q + SLOT_WIDTH'(1);
                    end else begin
                        symbol_num_d = symbol_num_q + 4'd1;
                    end
                    long_cp_d = is_long_cp(symbol_num_d, LONG_CP_PERIOD);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            trigger_q      <= 1'b0;
            long_cp_q      <= 1'b0;
            symbol_num_q   <= '0;
            slot_cnt_q     <= '0;
            sync_err_q     <= 1'b0;
            sync_err_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            trigger_q      <= trigger_d;
            long_cp_q      <= long_cp_d;
            symbol_num_q   <= symbol_num_d;
            slot_cnt_q     <= slot_cnt_d;
            sync_err_q     <= sync_err_d;
            sync_err_cnt_q <= sync_err_cnt_d;
        end
    end

    assign dout_trigger = trigger_q;
    assign long_cp      = long_cp_q;
    assign dout_sync    = sync_mode;
    assign symbol_num   = symbol_num_q;
    assign slot_cnt     = slot_cnt_q;
    assign busy         = (state_q == RUN);
    assign sync_err     = sync_err_q;
    assign sync_err_cnt = sync_err_cnt_q;

endmodule

// File: tb/tb_cp_symbol_scheduler.sv
// Directed bench for cp_symbol_scheduler: inputs driven and outputs sampled on the falling edge.
module tb_cp_symbol_scheduler;

    localparam int LONG  = 4448;
    localparam int SHORT = 4384;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        slot_sync;
    logic        sample_valid;
    logic        sync_mode;
    logic        dout_trigger;
    logic        long_cp;
    logic        dout_sync;
    logic [3:0]  symbol_num;
    logic [15:0] slot_cnt;
    logic [12:0] sample_cnt;
    logic        busy;
    logic        sync_err;
    logic [7:0]  sync_err_cnt;

    int checks   = 0;
    int failures = 0;
    int total    = 0;
    bit b2b_seen = 0;
    bit err_seen = 0;

    cp_symbol_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .slot_sync    (slot_sync),
        .sample_valid (sample_valid),
        .sync_mode    (sync_mode),
        .dout_trigger (dout_trigger),
        .long_cp      (long_cp),
        .dout_sync    (dout_sync),
        .symbol_num   (symbol_num),
        .slot_cnt     (slot_cnt),
        .sample_cnt   (sample_cnt),
        .busy         (busy),
        .sync_err     (sync_err),
        .sync_err_cnt (sync_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance until the next trigger; half toggles sample_valid each cycle,
    // arm raises slot_sync on the last sample of symbol 13.
    task automatic wait_trig(input int max, input bit half, input bit arm,
                             output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            cyc++;
            if (half) sample_valid = ~sample_valid;
            slot_sync = arm && (symbol_num == 4'd13) && (sample_cnt == 13'd4383) && sample_valid;
            if (dout_trigger && cyc == 1) b2b_seen = 1'b1;
            if (sync_err) err_seen = 1'b1;
            if (dout_trigger) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; slot_sync = 1'b1; sample_valid = 1'b1; sync_mode = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({dout_trigger, long_cp, busy, sync_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got trig/long/busy/err=%b want 0000",
                     {dout_trigger, long_cp, busy, sync_err});
        end
        checks++;
        if ({symbol_num, slot_cnt, sample_cnt, sync_err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_counters: got sym=%0d slot=%0d smp=%0d errcnt=%0d want all 0",
                     symbol_num, slot_cnt, sample_cnt, sync_err_cnt);
        end
        checks++;
        if (dout_sync !== 1'b1) begin
            failures++;
            $display("FAIL dout_sync_hi: got %b want 1", dout_sync);
        end
        sync_mode = 1'b0;
        #1;
        checks++;
        if (dout_sync !== 1'b0) begin
            failures++;
            $display("FAIL dout_sync_lo: got %b want 0", dout_sync);
        end
        slot_sync = 1'b0;
        enable    = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_first_symbol();
        int cyc;
        bit to;
        @(negedge clk);
        rst = 1'b0; enable = 1'b1; sample_valid = 1'b1;      // cycle 0
        repeat (9) @(negedge clk);                            // cycle 9
        checks++;
        if ({busy, dout_trigger} !== 2'b00) begin
            failures++;
            $display("FAIL wait_sync_idle: got busy/trig=%b want 00", {busy, dout_trigger});
        end
        @(negedge clk); slot_sync = 1'b1;                     // cycle 10
        @(negedge clk); slot_sync = 1'b0;                     // cycle 11
        checks++;
        if ({dout_trigger, long_cp, busy, symbol_num, sample_cnt} !== {3'b111, 4'd0, 13'd0}) begin
            failures++;
            $display("FAIL first_trig: got trig=%b long=%b busy=%b sym=%0d smp=%0d want 1 1 1 0 0",
                     dout_trigger, long_cp, busy, symbol_num, sample_cnt);
        end
        wait_trig(5000, 1'b0, 1'b0, cyc, to);
        checks++;
        if (to || cyc != LONG || long_cp !== 1'b0 || symbol_num !== 4'd1) begin
            failures++;
            $display("FAIL sym1_trig: got gap=%0d timeout=%b long=%b sym=%0d want gap=%0d long=0 sym=1",
                     cyc, to, long_cp, symbol_num, LONG);
        end
        total = cyc;
        $display("test_first_symbol: second trigger %0d cycles after first", cyc);
    endtask

    task automatic test_full_slot();
        int cyc;
        bit to;
        int exp_gap;
        int exp_sym;
        err_seen = 1'b0;
        for (int k = 2; k <= 14; k++) begin
            exp_sym = k % 14;
            exp_gap = ((k - 1) % 7 == 0) ? LONG : SHORT;
            wait_trig(5000, 1'b0, (k == 14), cyc, to);
            slot_sync = 1'b0;
            total += cyc;
            checks++;
            if (to || cyc != exp_gap || symbol_num !== 4'(exp_sym) ||
                long_cp !== ((exp_sym % 7) == 0)) begin
                failures++;
                $display("FAIL slot_sym%0d: got gap=%0d timeout=%b sym=%0d long=%b want gap=%0d sym=%0d long=%b",
                         exp_sym, cyc, to, symbol_num, long_cp, exp_gap, exp_sym, ((exp_sym % 7) == 0));
            end
        end
        checks++;
        if (total != 61504) begin
            failures++;
            $display("FAIL slot_period: got %0d want 61504", total);
        end
        checks++;
        if (slot_cnt !== 16'd1) begin
            failures++;
            $display("FAIL slot_cnt: got %0d want 1", slot_cnt);
        end
        checks++;
        if (err_seen !== 1'b0 || sync_err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL aligned_sync: got err_seen=%b errcnt=%0d want 0 0", err_seen, sync_err_cnt);
        end
        $display("test_full_slot: slot period %0d cycles slot_cnt=%0d", total, slot_cnt);
    endtask

    task automatic test_half_rate();
        int cyc;
        bit to;
        sample_valid = 1'b0;
        b2b_seen = 1'b0;
        wait_trig(10000, 1'b1, 1'b0, cyc, to);
        checks++;
        if (to || cyc != 8896 || symbol_num !== 4'd1 || long_cp !== 1'b0) begin
            failures++;
            $display("FAIL half_long: got gap=%0d timeout=%b sym=%0d long=%b want 8896 1 0",
                     cyc, to, symbol_num, long_cp);
        end
        wait_trig(10000, 1'b1, 1'b0, cyc, to);
        checks++;
        if (to || cyc != 8768 || symbol_num !== 4'd2 || long_cp !== 1'b0) begin
            failures++;
            $display("FAIL half_short: got gap=%0d timeout=%b sym=%0d long=%b want 8768 2 0",
                     cyc, to, symbol_num, long_cp);
        end
        checks++;
        if (b2b_seen !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back: got b2b=%b want 0", b2b_seen);
        end
        sample_valid = 1'b1;
        $display("test_half_rate: long/short spacing checked");
    endtask

    task automatic test_misaligned();
        int cyc;
        bit to;
        bit found;
        wait_trig(5000, 1'b0, 1'b0, cyc, to);
        checks++;
        if (to || cyc != SHORT || symbol_num !== 4'd3) begin
            failures++;
            $display("FAIL sym3_trig: got gap=%0d timeout=%b sym=%0d want %0d 3", cyc, to, symbol_num, SHORT);
        end
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (symbol_num == 4'd3 && sample_cnt == 13'd100) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reach_sample100: got sample_cnt=%0d want 100", sample_cnt);
        end
        slot_sync = 1'b1;
        @(negedge clk); slot_sync = 1'b0;
        checks++;
        if ({sync_err, dout_trigger, long_cp} !== 3'b111 || sync_err_cnt !== 8'd1 ||
            symbol_num !== 4'd0 || sample_cnt !== 13'd0 || slot_cnt !== 16'd1) begin
            failures++;
            $display("FAIL misaligned: got err=%b trig=%b long=%b errcnt=%0d sym=%0d smp=%0d slot=%0d want 1 1 1 1 0 0 1",
                     sync_err, dout_trigger, long_cp, sync_err_cnt, symbol_num, sample_cnt, slot_cnt);
        end
        @(negedge clk);
        checks++;
        if ({sync_err, dout_trigger} !== 2'b00) begin
            failures++;
            $display("FAIL err_pulse_width: got err/trig=%b want 00", {sync_err, dout_trigger});
        end
        $display("test_misaligned: sync_err_cnt=%0d", sync_err_cnt);
    endtask

    task automatic test_enable_drop();
        bit trig_seen;
        repeat (19) @(negedge clk);                  // 20 samples into symbol 0
        checks++;
        if (sample_cnt !== 13'd20) begin
            failures++;
            $display("FAIL pre_drop_cnt: got %0d want 20", sample_cnt);
        end
        enable = 1'b0; slot_sync = 1'b1;             // enable wins over slot_sync
        @(negedge clk); slot_sync = 1'b0;
        checks++;
        if ({busy, sync_err, dout_trigger} !== 3'b000 || symbol_num !== 4'd0 ||
            long_cp !== 1'b1 || sample_cnt !== 13'd20) begin
            failures++;
            $display("FAIL enable_drop: got busy=%b err=%b trig=%b sym=%0d long=%b smp=%0d want 0 0 0 0 1 20",
                     busy, sync_err, dout_trigger, symbol_num, long_cp, sample_cnt);
        end
        trig_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            slot_sync = (i == 10);
            @(negedge clk);
            if (dout_trigger || busy) trig_seen = 1'b1;
        end
        slot_sync = 1'b0;
        checks++;
        if (trig_seen !== 1'b0 || sample_cnt !== 13'd20) begin
            failures++;
            $display("FAIL idle_quiet: got activity=%b smp=%0d want 0 20", trig_seen, sample_cnt);
        end
        enable = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, dout_trigger} !== 2'b00) begin
            failures++;
            $display("FAIL reenable_wait: got busy/trig=%b want 00", {busy, dout_trigger});
        end
        slot_sync = 1'b1;
        @(negedge clk); slot_sync = 1'b0;
        checks++;
        if ({dout_trigger, busy, long_cp} !== 3'b111 || symbol_num !== 4'd0 || sample_cnt !== 13'd0) begin
            failures++;
            $display("FAIL reenable_trig: got trig=%b busy=%b long=%b sym=%0d smp=%0d want 1 1 1 0 0",
                     dout_trigger, busy, long_cp, symbol_num, sample_cnt);
        end
        $display("test_enable_drop done");
    endtask

    task automatic test_reset_mid();
        bit trig_seen;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dout_trigger, long_cp, busy, sync_err} !== 4'b0000 ||
            {symbol_num, slot_cnt, sample_cnt, sync_err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got trig=%b long=%b busy=%b err=%b sym=%0d slot=%0d smp=%0d errcnt=%0d want all 0",
                     dout_trigger, long_cp, busy, sync_err, symbol_num, slot_cnt, sample_cnt, sync_err_cnt);
        end
        @(negedge clk); rst = 1'b0;
        trig_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (dout_trigger) trig_seen = 1'b1;
        end
        checks++;
        if (trig_seen !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_trig: got trigger=%b want 0", trig_seen);
        end
        slot_sync = 1'b1;
        @(negedge clk); slot_sync = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); slot_sync = 1'b1;
            @(negedge clk); slot_sync = 1'b0;
        end
        checks++;
        if (sync_err_cnt !== 8'd255 || sync_err !== 1'b1) begin
            failures++;
            $display("FAIL err_saturate: got errcnt=%0d err=%b want 255 1", sync_err_cnt, sync_err);
        end
        $display("test_reset_mid: sync_err_cnt=%0d after 300 misaligned syncs", sync_err_cnt);
    endtask

    initial begin
        test_reset();
        test_first_symbol();
        test_full_slot();
        test_half_rate();
        test_misaligned();
        test_enable_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
